// File: rtl/fetch_sequencer.sv
// Fetch/control sequencer: fetches one instruction per pass,
// hands it to execute, then issues one PC update command.
module fetch_sequencer #(
   parameter logic [5:0]  JUMP_OP       = 6'b000010,
   parameter logic [5:0]  BEQ_OP        = 6'b000100,
   parameter logic [5:0]  BNE_OP        = 6'b000101,
   parameter int unsigned FETCH_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [1:0]  ps,
   output logic [29:0] pc_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   output logic        ir_valid,
   input  logic        exec_ready,
   input  logic        zero,
   output logic        fetch_err
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      UPDATE,
      HALT
   } state_t;

   localparam logic [15:0] TO_LAST =
      16'(FETCH_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [1:0]  ps_q, ps_d;
   logic [29:0] pc_in_q, pc_in_d;
   logic [31:0] ir_q, ir_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;

   logic [5:0]  op;
   logic [15:0] imm;
   logic        is_jump;
   logic        br_taken;

   assign op  = ir_q[31:26];
   assign imm = ir_q[15:0];

   assign is_jump  = (op == JUMP_OP);
   assign br_taken = ((op == BEQ_OP) && zero) ||
                     ((op == BNE_OP) && !zero);

   always_comb begin
      state_d  = state_q;
      ps_d     = ps_q;
      pc_in_d  = pc_in_q;
      ir_d     = ir_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      imem_req = 1'b0;
      ir_valid = 1'b0;
      unique case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            imem_req = 1'b1;
            // an ack on the final allowed cycle still wins
            if (imem_ack) begin
               ir_d    = imem_rdata;
               cnt_d   = '0;
               state_d = DECODE;
            end else if (cnt_q == TO_LAST) begin
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = HALT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DECODE: begin
            ir_valid = 1'b1;
            if (exec_ready) begin
               state_d = UPDATE;
               unique case (1'b1)
                  is_jump: begin
                     ps_d    = 2'b11;
                     pc_in_d = {4'b0, ir_q[25:0]};
                  end
                  br_taken: begin
                     ps_d    = 2'b10;
                     pc_in_d = {{14{imm[15]}}, imm};
                  end
                  default: begin
                     ps_d    = 2'b01;
                     pc_in_d = '0;
                  end
               endcase
            end
         end
         UPDATE: begin
            ps_d    = 2'b00;
            pc_in_d = '0;
            state_d = FETCH;
         end
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         ps_q    <= 2'b00;
         pc_in_q <= '0;
         ir_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ps_q    <= ps_d;
         pc_in_q <= pc_in_d;
         ir_q    <= ir_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ps        = ps_q;
   assign pc_in     = pc_in_q;
   assign ir        = ir_q;
   assign fetch_err = err_q;
   assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small PC model
// and hand-computed expected values.
module tb_fetch_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [1:0]  ps;
   logic [29:0] pc_in;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ir;
   logic        ir_valid;
   logic        exec_ready;
   logic        zero;
   logic        fetch_err;

   int nvec = 0;
   int nerr = 0;

   always #5 clock = ~clock;

   fetch_sequencer #(.FETCH_TIMEOUT(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .pc         (pc),
      .ps         (ps),
      .pc_in      (pc_in),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .ir         (ir),
      .ir_valid   (ir_valid),
      .exec_ready (exec_ready),
      .zero       (zero),
      .fetch_err  (fetch_err)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
      end
   endtask

   // one clock; the PC model applies the command seen
   // before the edge, then we wait for the next negedge
   task automatic cyc();
      logic [1:0]  s;
      logic [29:0] o;
      s = ps;
      o = pc_in;
      @(posedge clock);
      #1;
      if (reset) pc = '0;
      else begin
         case (s)
            2'b01: pc = pc + 32'd4;
            2'b11: pc = {2'b00, o};
            2'b10: pc = pc + 32'd4 + {o, 2'b00};
            default: ;
         endcase
      end
      @(negedge clock);
   endtask

   // run one instruction from FETCH back to FETCH
   task automatic run3();
      cyc();
      cyc();
      cyc();
   endtask

   initial begin
      reset      = 1'b1;
      pc         = '0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      exec_ready = 1'b0;
      zero       = 1'b0;
      @(negedge clock);
      cyc();
      check("rst_ps", 32'(ps), 0);
      check("rst_pcin", 32'(pc_in), 0);
      check("rst_ir", ir, 0);
      check("rst_irv", 32'(ir_valid), 0);
      check("rst_err", 32'(fetch_err), 0);
      check("rst_req", 32'(imem_req), 0);

      reset      = 1'b0;
      imem_ack   = 1'b1;
      exec_ready = 1'b1;
      cyc();
      for (int k = 0; k < 4; k++) begin
         check("seq_addr", imem_addr, 32'(4 * k));
         check("seq_req", 32'(imem_req), 1);
         check("seq_ps_f", 32'(ps), 0);
         cyc();
         check("seq_ps_d", 32'(ps), 0);
         cyc();
         check("seq_ps_u", 32'(ps), 1);
         cyc();
      end
      check("seq_end", imem_addr, 'h10);

      imem_rdata = 32'h0800_0040;
      cyc();
      check("j_ir", ir, 'h0800_0040);
      cyc();
      check("j_ps", 32'(ps), 3);
      check("j_pcin", 32'(pc_in), 'h40);
      cyc();
      check("j_addr", imem_addr, 'h40);
      check("j_ps0", 32'(ps), 0);

      imem_rdata = 32'h0800_0020;
      run3();
      check("j2_addr", imem_addr, 'h20);

      imem_rdata = 32'h1000_FFFE;
      zero       = 1'b1;
      cyc();
      cyc();
      check("beq_ps", 32'(ps), 2);
      check("beq_pcin", 32'(pc_in), 'h3FFF_FFFE);
      cyc();
      check("beq_addr", imem_addr, 'h1C);

      imem_rdata = '0;
      run3();
      check("nop_addr", imem_addr, 'h20);

      imem_rdata = 32'h1000_FFFE;
      zero       = 1'b0;
      cyc();
      cyc();
      check("beqn_ps", 32'(ps), 1);
      check("beqn_pcin", 32'(pc_in), 0);
      cyc();
      check("beqn_addr", imem_addr, 'h24);

      imem_rdata = 32'h1400_0003;
      cyc();
      cyc();
      check("bne_ps", 32'(ps), 2);
      check("bne_pcin", 32'(pc_in), 3);
      cyc();
      check("bne_addr", imem_addr, 'h34);

      imem_rdata = 32'hDEAD_BEEF;
      exec_ready = 1'b0;
      cyc();
      imem_rdata = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         check("stall_irv", 32'(ir_valid), 1);
         check("stall_ir", ir, 'hDEAD_BEEF);
         check("stall_ps", 32'(ps), 0);
         cyc();
      end
      exec_ready = 1'b1;
      cyc();
      check("stall_upd", 32'(ps), 1);
      cyc();
      check("stall_addr", imem_addr, 'h38);

      imem_ack   = 1'b0;
      imem_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         check("late_req", 32'(imem_req), 1);
         cyc();
      end
      imem_ack = 1'b1;
      cyc();
      check("late_irv", 32'(ir_valid), 1);
      check("late_err", 32'(fetch_err), 0);
      cyc();
      cyc();
      check("late_addr", imem_addr, 'h3C);

      imem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("to_req", 32'(imem_req), 1);
         cyc();
      end
      check("halt_req", 32'(imem_req), 0);
      check("halt_err", 32'(fetch_err), 1);
      check("halt_ps", 32'(ps), 0);
      check("halt_irv", 32'(ir_valid), 0);
      imem_ack = 1'b1;
      cyc();
      cyc();
      check("halt_ack_req", 32'(imem_req), 0);
      check("halt_ack_irv", 32'(ir_valid), 0);
      check("halt_ack_err", 32'(fetch_err), 1);
      reset = 1'b1;
      cyc();
      check("clr_err", 32'(fetch_err), 0);
      reset = 1'b0;

      exec_ready = 1'b0;
      imem_rdata = 32'h0800_0040;
      cyc();
      check("rd_addr", imem_addr, 0);
      cyc();
      check("rd_irv", 32'(ir_valid), 1);
      reset      = 1'b1;
      exec_ready = 1'b1;
      cyc();
      check("rd_ps", 32'(ps), 0);
      check("rd_pcin", 32'(pc_in), 0);
      check("rd_ir", ir, 0);
      check("rd_irv0", 32'(ir_valid), 0);
      check("rd_req", 32'(imem_req), 0);
      reset = 1'b0;
      cyc();
      check("rd_ps_next", 32'(ps), 0);
      check("rd_req_next", 32'(imem_req), 1);
      check("rd_addr_next", imem_addr, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
